// File: rtl/router_pkg.sv
// Shared definitions for the 1xN packet router: FSM state codes and
// small helpers for header decoding and derived widths.
package router_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_DROP   = 2'd3;

   // Address field width: enough bits to name every port, never fewer than one
   function automatic int calcAw(input int numPorts);
      return (numPorts <= 2) ? 1 : $clog2(numPorts);
   endfunction

   // Pointer width for a power-of-two FIFO, never fewer than one bit
   function automatic int calcPtrW(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Extract an unsigned bit field of a header word, right-aligned
   function automatic logic [31:0] hdrField(input logic [31:0] hdr,
                                           input int          lsb,
                                           input int          width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (hdr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO with first-word-fall-through read and a synchronous
// flush. The head word is forced to zero while the FIFO is empty so the
// router output never shows stale storage.
module router_fifo
   import router_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          wr_en_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   output logic [DW-1:0] rd_data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int PW = calcPtrW(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW:0]   wptr_q, wptr_d;
   logic [PW:0]   rptr_q, rptr_d;
   logic          wrFire;
   logic          rdFire;

   // Status flags, head word and next pointer values; flush wins over traffic
   always_comb begin
      empty_o   = (wptr_q == rptr_q);
      full_o    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
      rd_data_o = empty_o ? '0 : mem_q[rptr_q[PW-1:0]];
      wrFire    = wr_en_i && !full_o;
      rdFire    = rd_en_i && !empty_o;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wrFire) wptr_d = wptr_q + (PW+1)'(1);
         if (rdFire) rptr_d = rptr_q + (PW+1)'(1);
      end
   end

   // Pointer registers, cleared by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      if (wrFire && !flush_i) mem_q[wptr_q[PW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/router_1xn.sv
// Length-framed packet router: one byte-stream input steered into
// NUM_PORTS FWFT output FIFOs by the header address. Out-of-range
// addresses are consumed and dropped, parity is checked against a running
// XOR, and a port whose reader stalls for TIMEOUT cycles is soft-flushed.
module router_1xn
   import router_pkg::*;
#(
   parameter int DW        = 8,
   parameter int NUM_PORTS = 3,
   parameter int DEPTH     = 16,
   parameter int TIMEOUT   = 30
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW-1:0]           data,
   input  logic                    pkt_valid,
   input  logic [NUM_PORTS-1:0]    rd_en,
   output logic [NUM_PORTS-1:0]    vld_out,
   output logic [NUM_PORTS*DW-1:0] dout,
   output logic                    busy,
   output logic                    err
);

   localparam int AW = calcAw(NUM_PORTS);
   localparam int LW = DW - AW;
   localparam int RW = LW + 1;
   localparam int PW = 2 ** AW;
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [DW-1:0] par_q, par_d;
   logic          err_q, err_d;

   logic [NUM_PORTS-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NUM_PORTS-1:0] full, empty, wrEn, flush, stall;
   logic [PW-1:0]        fullPad, flushPad;

   logic [AW-1:0] hdrAddr;
   logic [LW-1:0] hdrLen;
   logic          hdrValid;
   logic [AW-1:0] tgtAddr;
   logic          tgtFlush;
   logic          accept;
   logic          writing;

   // Header field decode and per-port flags padded to the full address space
   always_comb begin
      hdrAddr  = AW'(hdrField(32'(data), 0, AW));
      hdrLen   = LW'(hdrField(32'(data), AW, LW));
      hdrValid = int'(hdrAddr) < NUM_PORTS;
      fullPad  = '0;
      flushPad = '0;
      fullPad[NUM_PORTS-1:0]  = full;
      flushPad[NUM_PORTS-1:0] = flush;
   end

   // Backpressure, word acceptance and per-port write enables
   always_comb begin
      busy = 1'b0;
      case (state_q)
         ST_IDLE:             busy = pkt_valid && hdrValid && fullPad[hdrAddr];
         ST_LOAD, ST_PARITY:  busy = fullPad[addr_q];
         default:             busy = 1'b0;
      endcase
      accept   = ((state_q != ST_IDLE) || pkt_valid) && !busy;
      tgtAddr  = (state_q == ST_IDLE) ? hdrAddr : addr_q;
      tgtFlush = flushPad[tgtAddr];
      writing  = accept && (((state_q == ST_IDLE) && hdrValid) ||
                            (state_q == ST_LOAD) || (state_q == ST_PARITY));
      for (int i = 0; i < NUM_PORTS; i++) begin
         wrEn[i] = writing && (int'(tgtAddr) == i);
      end
   end

   // Stall timers: a port flushes on the edge its timer would reach TIMEOUT
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         stall[i] = vld_out[i] && !rd_en[i];
         flush[i] = stall[i] && (cnt_q[i] == CW'(TIMEOUT - 1));
         cnt_d[i] = (stall[i] && !flush[i]) ? cnt_q[i] + CW'(1) : '0;
      end
   end

   // Packet framing FSM; a flush of the port being written diverts to DROP
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      par_d   = par_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d = hdrAddr;
               par_d  = data;
               if (!hdrValid || tgtFlush) begin
                  rem_d   = {1'b0, hdrLen} + RW'(1);
                  state_d = ST_DROP;
               end else begin
                  rem_d   = {1'b0, hdrLen};
                  state_d = (hdrLen == '0) ? ST_PARITY : ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (tgtFlush) begin
               rem_d   = accept ? rem_q : rem_q + RW'(1);
               state_d = ST_DROP;
            end else if (accept) begin
               par_d = par_q ^ data;
               rem_d = rem_q - RW'(1);
               if (rem_q == RW'(1)) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (tgtFlush) begin
               if (accept) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  rem_d   = RW'(1);
                  state_d = ST_DROP;
               end
            end else if (accept) begin
               err_d   = (data != par_q);
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (accept) begin
               rem_d = rem_q - RW'(1);
               if (rem_q == RW'(1)) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers and stall timers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         par_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         par_q   <= par_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err     = err_q;
   assign vld_out = ~empty;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : gPort
      router_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) uFifo (
         .clk       (clk),
         .rst       (rst),
         .flush_i   (flush[g]),
         .wr_en_i   (wrEn[g]),
         .wr_data_i (data),
         .rd_en_i   (rd_en[g]),
         .rd_data_o (dout[g*DW +: DW]),
         .full_o    (full[g]),
         .empty_o   (empty[g])
      );
   end

endmodule

// File: tb/tb_router_1xn.sv
// Directed testbench for router_1xn. Instance A uses DEPTH=16 for the
// routing, parity, drop, timeout and reset scenarios; instance B uses
// DEPTH=4 to exercise backpressure.
module tb_router_1xn;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  dataA, dataB;
   logic        pktValidA, pktValidB;
   logic [2:0]  rdEnA, rdEnB;
   logic [2:0]  vldA, vldB;
   logic [23:0] doutA, doutB;
   logic        busyA, busyB, errA, errB;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   router_1xn #(.DW(8), .NUM_PORTS(3), .DEPTH(16), .TIMEOUT(30)) dutA (
      .clk(clk), .rst(rst), .data(dataA), .pkt_valid(pktValidA), .rd_en(rdEnA),
      .vld_out(vldA), .dout(doutA), .busy(busyA), .err(errA)
   );

   router_1xn #(.DW(8), .NUM_PORTS(3), .DEPTH(4), .TIMEOUT(30)) dutB (
      .clk(clk), .rst(rst), .data(dataB), .pkt_valid(pktValidB), .rd_en(rdEnB),
      .vld_out(vldB), .dout(doutB), .busy(busyB), .err(errB)
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outputs while reset is held
   task automatic test_reset();
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL reset_vld: got %b want 000", vldA); else passes++;
      checks++; if (doutA !== 24'h0) $display("[TB] FAIL reset_dout: got %h want 000000", doutA); else passes++;
      checks++; if (busyA !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busyA); else passes++;
      checks++; if (errA !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", errA); else passes++;
   endtask

   // Good or bad-parity packet to port 1, then read back all six words
   task automatic test_packet(input logic [7:0] parity, input logic expErr);
      logic [7:0] exp [6];
      exp = '{8'h11, 8'hA1, 8'hA2, 8'hA3, 8'hA4, parity};
      dataA = 8'h11; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      checks++; if (vldA !== 3'b010) $display("[TB] FAIL pkt_vld: got %b want 010", vldA); else passes++;
      checks++; if (doutA[15:8] !== 8'h11) $display("[TB] FAIL pkt_hdr_fwft: got %h want 11", doutA[15:8]); else passes++;
      for (int k = 1; k < 6; k++) begin
         dataA = exp[k];
         tick();
      end
      checks++; if (errA !== expErr) $display("[TB] FAIL pkt_err: got %b want %b", errA, expErr); else passes++;
      tick();
      checks++; if (errA !== 1'b0) $display("[TB] FAIL pkt_err_pulse: got %b want 0", errA); else passes++;
      checks++; if (busyA !== 1'b0) $display("[TB] FAIL pkt_busy: got %b want 0", busyA); else passes++;
      rdEnA = 3'b010;
      for (int k = 0; k < 6; k++) begin
         checks++; if (doutA[15:8] !== exp[k]) $display("[TB] FAIL pkt_pop%0d: got %h want %h", k, doutA[15:8], exp[k]); else passes++;
         tick();
      end
      rdEnA = 3'b000;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL pkt_drained: got %b want 000", vldA); else passes++;
   endtask

   // Invalid address is dropped, then the next packet to port 0 routes normally
   task automatic test_drop();
      logic [7:0] exp [3];
      exp = '{8'h04, 8'h5A, 8'h5E};
      dataA = 8'h0B; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL drop_vld: got %b want 000", vldA); else passes++;
      for (int k = 0; k < 3; k++) begin
         dataA = 8'hC0 + 8'(k);
         checks++; if (busyA !== 1'b0) $display("[TB] FAIL drop_busy%0d: got %b want 0", k, busyA); else passes++;
         tick();
         if (k < 2) begin
            checks++; if (errA !== 1'b0) $display("[TB] FAIL drop_err_early%0d: got %b want 0", k, errA); else passes++;
         end
      end
      checks++; if (errA !== 1'b1) $display("[TB] FAIL drop_err: got %b want 1", errA); else passes++;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL drop_vld_end: got %b want 000", vldA); else passes++;
      dataA = 8'h04; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      checks++; if (errA !== 1'b0) $display("[TB] FAIL drop_err_pulse: got %b want 0", errA); else passes++;
      dataA = 8'h5A; tick();
      dataA = 8'h5E; tick();
      checks++; if (vldA !== 3'b001) $display("[TB] FAIL next_vld: got %b want 001", vldA); else passes++;
      checks++; if (errA !== 1'b0) $display("[TB] FAIL next_err: got %b want 0", errA); else passes++;
      rdEnA = 3'b001;
      for (int k = 0; k < 3; k++) begin
         checks++; if (doutA[7:0] !== exp[k]) $display("[TB] FAIL next_pop%0d: got %h want %h", k, doutA[7:0], exp[k]); else passes++;
         tick();
      end
      rdEnA = 3'b000;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL next_drained: got %b want 000", vldA); else passes++;
   endtask

   // DEPTH=4: LEN=6 packet to port 2 stalls until the reader starts
   task automatic test_back_to_back();
      logic [7:0] words [8];
      logic [7:0] recv  [8];
      logic [7:0] headNow;
      logic       accNow, popNow, errSeen;
      int         idx, got;
      words = '{8'h1A, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'h1D};
      recv  = '{default: 8'h00};
      dataB = words[0]; pktValidB = 1'b1; tick(); pktValidB = 1'b0;
      for (int k = 1; k < 4; k++) begin
         dataB = words[k];
         tick();
      end
      dataB = words[4];
      checks++; if (busyB !== 1'b1) $display("[TB] FAIL bp_busy_full: got %b want 1", busyB); else passes++;
      tick();
      checks++; if (busyB !== 1'b1) $display("[TB] FAIL bp_busy_hold: got %b want 1", busyB); else passes++;
      checks++; if (vldB !== 3'b100) $display("[TB] FAIL bp_vld: got %b want 100", vldB); else passes++;
      rdEnB = 3'b100;
      idx = 4; got = 0; errSeen = 1'b0;
      for (int cyc = 0; cyc < 60 && (idx < 8 || got < 8); cyc++) begin
         if (idx < 8) dataB = words[idx];
         accNow  = !busyB && (idx < 8);
         popNow  = vldB[2];
         headNow = doutB[23:16];
         tick();
         errSeen = errSeen | errB;
         if (accNow) idx++;
         if (popNow) begin
            if (got < 8) recv[got] = headNow;
            got++;
         end
      end
      rdEnB = 3'b000;
      checks++; if (got !== 8) $display("[TB] FAIL bp_count: got %0d want 8", got); else passes++;
      for (int k = 0; k < 8; k++) begin
         checks++; if (recv[k] !== words[k]) $display("[TB] FAIL bp_word%0d: got %h want %h", k, recv[k], words[k]); else passes++;
      end
      checks++; if (errSeen !== 1'b0) $display("[TB] FAIL bp_err: got %b want 0", errSeen); else passes++;
      checks++; if (vldB !== 3'b000) $display("[TB] FAIL bp_drained: got %b want 000", vldB); else passes++;
   endtask

   // Port 0 stalls for 30 cycles and is flushed; port 1 keeps its data
   task automatic test_timeout();
      dataA = 8'h04; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      dataA = 8'h77; tick();
      dataA = 8'h73; tick();
      dataA = 8'h01; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      dataA = 8'h01; tick();
      repeat (25) tick();
      checks++; if (vldA[0] !== 1'b1) $display("[TB] FAIL to_vld_c30: got %b want 1", vldA[0]); else passes++;
      checks++; if (doutA[7:0] !== 8'h04) $display("[TB] FAIL to_head_c30: got %h want 04", doutA[7:0]); else passes++;
      tick();
      checks++; if (vldA[0] !== 1'b0) $display("[TB] FAIL to_vld_c31: got %b want 0", vldA[0]); else passes++;
      checks++; if (doutA[7:0] !== 8'h00) $display("[TB] FAIL to_head_c31: got %h want 00", doutA[7:0]); else passes++;
      checks++; if (vldA[2:1] !== 2'b01) $display("[TB] FAIL to_others: got %b want 01", vldA[2:1]); else passes++;
      checks++; if (errA !== 1'b0) $display("[TB] FAIL to_err: got %b want 0", errA); else passes++;
      rdEnA = 3'b010;
      checks++; if (doutA[15:8] !== 8'h01) $display("[TB] FAIL to_p1_hdr: got %h want 01", doutA[15:8]); else passes++;
      tick();
      checks++; if (doutA[15:8] !== 8'h01) $display("[TB] FAIL to_p1_par: got %h want 01", doutA[15:8]); else passes++;
      tick();
      rdEnA = 3'b000;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL to_drained: got %b want 000", vldA); else passes++;
   endtask

   // Reset in the middle of a packet, then a fresh LEN=0 packet to port 0
   task automatic test_reset_mid();
      dataA = 8'h12; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      dataA = 8'hE1; tick();
      dataA = 8'hE2; tick();
      checks++; if (vldA !== 3'b100) $display("[TB] FAIL rm_before: got %b want 100", vldA); else passes++;
      #2 rst = 1'b0;
      #1;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL rm_vld: got %b want 000", vldA); else passes++;
      checks++; if (doutA !== 24'h0) $display("[TB] FAIL rm_dout: got %h want 000000", doutA); else passes++;
      checks++; if (busyA !== 1'b0) $display("[TB] FAIL rm_busy: got %b want 0", busyA); else passes++;
      checks++; if (errA !== 1'b0) $display("[TB] FAIL rm_err: got %b want 0", errA); else passes++;
      tick();
      rst = 1'b1;
      tick();
      dataA = 8'h00; pktValidA = 1'b1; tick(); pktValidA = 1'b0;
      dataA = 8'h00; tick();
      checks++; if (vldA !== 3'b001) $display("[TB] FAIL rm_new_vld: got %b want 001", vldA); else passes++;
      checks++; if (errA !== 1'b0) $display("[TB] FAIL rm_new_err: got %b want 0", errA); else passes++;
      rdEnA = 3'b001;
      tick();
      checks++; if (vldA !== 3'b001) $display("[TB] FAIL rm_pop1: got %b want 001", vldA); else passes++;
      tick();
      rdEnA = 3'b000;
      checks++; if (vldA !== 3'b000) $display("[TB] FAIL rm_pop2: got %b want 000", vldA); else passes++;
   endtask

   initial begin
      rst = 1'b0;
      dataA = 8'h00; dataB = 8'h00;
      pktValidA = 1'b0; pktValidB = 1'b0;
      rdEnA = 3'b000; rdEnB = 3'b000;
      #3;
      test_reset();
      tick();
      rst = 1'b1;
      tick();
      test_packet(8'h15, 1'b0);
      test_packet(8'h16, 1'b1);
      test_drop();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
